// File: rtl/header_byte_loader.sv
// Framed host byte stream -> SHA-256 midstate and header-tail registers.
// Produces start/done handshake flags for the mining controller.
module header_byte_loader #(
   parameter int unsigned MID_BYTES  = 32,
   parameter int unsigned TAIL_BYTES = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    byte_valid,
   input  logic [7:0]              byte_data,
   input  logic                    byte_sof,
   output logic                    start_found,
   output logic                    midstate_shifts_done,
   output logic                    remaining_shifts_done,
   output logic [8*MID_BYTES-1:0]  midstate,
   output logic [8*TAIL_BYTES-1:0] header_tail,
   output logic                    frame_err
);

   localparam int unsigned MID_W     = 8 * MID_BYTES;
   localparam int unsigned TAIL_W    = 8 * TAIL_BYTES;
   localparam int unsigned MAX_BYTES = (MID_BYTES > TAIL_BYTES) ? MID_BYTES : TAIL_BYTES;
   localparam int unsigned CNT_W     = $clog2(MAX_BYTES + 1);

   typedef enum logic [1:0] {
      WAIT_SOF   = 2'd0,
      SHIFT_MID  = 2'd1,
      SHIFT_TAIL = 2'd2,
      FULL       = 2'd3
   } state_t;

   state_t             state, state_d;
   logic [CNT_W-1:0]   byte_cnt, cnt_d;
   logic [MID_W-1:0]   mid_d;
   logic [TAIL_W-1:0]  tail_d;
   logic               start_d, mid_done_d, rem_done_d, err_d;

   // State, counter, shift registers and flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state                 <= WAIT_SOF;
         byte_cnt              <= '0;
         midstate              <= '0;
         header_tail           <= '0;
         start_found           <= 1'b0;
         midstate_shifts_done  <= 1'b0;
         remaining_shifts_done <= 1'b0;
         frame_err             <= 1'b0;
      end else begin
         state                 <= state_d;
         byte_cnt              <= cnt_d;
         midstate              <= mid_d;
         header_tail           <= tail_d;
         start_found           <= start_d;
         midstate_shifts_done  <= mid_done_d;
         remaining_shifts_done <= rem_done_d;
         frame_err             <= err_d;
      end
   end

   // Next-state and next-output logic; a sof restarts the frame from any state
   always_comb begin
      state_d    = state;
      cnt_d      = byte_cnt;
      mid_d      = midstate;
      tail_d     = header_tail;
      start_d    = 1'b0;
      mid_done_d = midstate_shifts_done;
      rem_done_d = remaining_shifts_done;
      err_d      = frame_err;

      if (byte_valid && byte_sof) begin
         state_d    = SHIFT_MID;
         cnt_d      = '0;
         start_d    = 1'b1;
         mid_done_d = 1'b0;
         rem_done_d = 1'b0;
         err_d      = 1'b0;
      end else if (byte_valid) begin
         case (state)
            SHIFT_MID: begin
               mid_d = {midstate[MID_W-9:0], byte_data};
               if (byte_cnt == CNT_W'(MID_BYTES - 1)) begin
                  cnt_d      = '0;
                  mid_done_d = 1'b1;
                  state_d    = SHIFT_TAIL;
               end else begin
                  cnt_d = byte_cnt + CNT_W'(1);
               end
            end
            SHIFT_TAIL: begin
               tail_d = {header_tail[TAIL_W-9:0], byte_data};
               if (byte_cnt == CNT_W'(TAIL_BYTES - 1)) begin
                  cnt_d      = '0;
                  rem_done_d = 1'b1;
                  state_d    = FULL;
               end else begin
                  cnt_d = byte_cnt + CNT_W'(1);
               end
            end
            default: err_d = 1'b1; // WAIT_SOF or FULL: byte is discarded
         endcase
      end
   end

endmodule

// File: tb/tb_header_byte_loader.sv
// Self-checking bench for header_byte_loader: directed frame scenarios plus
// randomized traffic against a byte-history reference model.
module tb_header_byte_loader;

   logic         clk = 1'b0;
   logic         rst;
   logic         byte_valid;
   logic [7:0]   byte_data;
   logic         byte_sof;
   logic         start_found;
   logic         midstate_shifts_done;
   logic         remaining_shifts_done;
   logic [255:0] midstate;
   logic [95:0]  header_tail;
   logic         frame_err;

   int n_checks = 0;
   int n_fail   = 0;

   header_byte_loader dut (
      .clk                   (clk),
      .rst                   (rst),
      .byte_valid            (byte_valid),
      .byte_data             (byte_data),
      .byte_sof              (byte_sof),
      .start_found           (start_found),
      .midstate_shifts_done  (midstate_shifts_done),
      .remaining_shifts_done (remaining_shifts_done),
      .midstate              (midstate),
      .header_tail           (header_tail),
      .frame_err             (frame_err)
   );

   always #5 clk = ~clk;

   // Reference model: a frame is "active" after a sof; n counts data bytes in it.
   // Registers are the last 32 / 12 bytes ever routed to each of them.
   logic       m_active, m_err, m_start;
   int         m_n;
   logic [7:0] mid_q[$];
   logic [7:0] tail_q[$];

   task automatic model_reset();
      m_active = 1'b0; m_err = 1'b0; m_start = 1'b0; m_n = 0;
      mid_q.delete(); tail_q.delete();
      for (int i = 0; i < 32; i++) mid_q.push_back(8'h00);
      for (int i = 0; i < 12; i++) tail_q.push_back(8'h00);
   endtask

   task automatic model_update(input logic v, input logic s, input logic [7:0] d, input logic r);
      if (r) begin
         model_reset();
      end else begin
         m_start = v && s;
         if (v && s) begin
            m_active = 1'b1; m_n = 0; m_err = 1'b0;
         end else if (v) begin
            if (m_active && m_n < 32) begin
               mid_q.push_back(d); void'(mid_q.pop_front()); m_n++;
            end else if (m_active && m_n < 44) begin
               tail_q.push_back(d); void'(tail_q.pop_front()); m_n++;
            end else begin
               m_err = 1'b1;
            end
         end
      end
   endtask

   function automatic logic [255:0] exp_mid();
      logic [255:0] r;
      for (int i = 0; i < 32; i++) r[255-8*i -: 8] = mid_q[i];
      return r;
   endfunction

   function automatic logic [95:0] exp_tail();
      logic [95:0] r;
      for (int i = 0; i < 12; i++) r[95-8*i -: 8] = tail_q[i];
      return r;
   endfunction

   function automatic logic exp_mid_done();
      return m_active && (m_n >= 32);
   endfunction

   function automatic logic exp_rem_done();
      return m_active && (m_n >= 44);
   endfunction

   // One clock: apply inputs, advance the model, leave outputs ready to sample
   task automatic step(input logic v, input logic s, input logic [7:0] d, input logic r);
      byte_valid = v; byte_sof = s; byte_data = d; rst = r;
      @(posedge clk);
      #1;
      model_update(v, s, d, r);
      byte_valid = 1'b0; byte_sof = 1'b0; rst = 1'b0;
   endtask

   task automatic test_reset();
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b0, 8'h5A, 1'b1);
      n_checks++;
      if ({start_found, midstate_shifts_done, remaining_shifts_done, frame_err} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b required 0000",
                  {start_found, midstate_shifts_done, remaining_shifts_done, frame_err});
      end
      n_checks++;
      if ({midstate, header_tail} !== 352'h0) begin
         n_fail++; $display("FAIL reset_regs: got %h %h required 0", midstate, header_tail);
      end
   endtask

   task automatic test_basic_frame();
      step(1'b1, 1'b1, 8'hFF, 1'b0);
      n_checks++;
      if (start_found !== 1'b1) begin n_fail++; $display("FAIL basic_start: got %b required 1", start_found); end
      for (int i = 0; i < 32; i++) begin
         step(1'b1, 1'b0, 8'(i), 1'b0);
         if (i == 0) begin
            n_checks++;
            if (start_found !== 1'b0) begin n_fail++; $display("FAIL basic_start_pulse: got %b required 0", start_found); end
         end
         if (i == 30) begin
            n_checks++;
            if (midstate_shifts_done !== 1'b0) begin n_fail++; $display("FAIL basic_mid_early: got %b required 0", midstate_shifts_done); end
         end
      end
      n_checks++;
      if (midstate_shifts_done !== 1'b1) begin n_fail++; $display("FAIL basic_mid_done: got %b required 1", midstate_shifts_done); end
      n_checks++;
      if (midstate !== 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f) begin
         n_fail++; $display("FAIL basic_midstate: got %h", midstate);
      end
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b0, 8'(8'hE0 + i), 1'b0);
         if (i == 10) begin
            n_checks++;
            if (remaining_shifts_done !== 1'b0) begin n_fail++; $display("FAIL basic_rem_early: got %b required 0", remaining_shifts_done); end
         end
      end
      n_checks++;
      if ({midstate_shifts_done, remaining_shifts_done} !== 2'b11) begin
         n_fail++; $display("FAIL basic_rem_done: got %b required 11", {midstate_shifts_done, remaining_shifts_done});
      end
      n_checks++;
      if (header_tail !== 96'hE0E1E2E3E4E5E6E7E8E9EAEB) begin
         n_fail++; $display("FAIL basic_tail: got %h required E0E1E2E3E4E5E6E7E8E9EAEB", header_tail);
      end
   endtask

   task automatic test_gapped();
      step(1'b1, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 44; i++) begin
         step(1'b0, 1'b0, 8'h77, 1'b0);
         if (i == 32) begin
            n_checks++;
            if (midstate_shifts_done !== 1'b1) begin n_fail++; $display("FAIL gap_mid_hold: got %b required 1", midstate_shifts_done); end
         end
         step(1'b1, 1'b0, (i < 32) ? 8'(i) : 8'(8'hE0 + i - 32), 1'b0);
         if (i == 31) begin
            n_checks++;
            if (midstate_shifts_done !== 1'b1) begin n_fail++; $display("FAIL gap_mid_done: got %b required 1", midstate_shifts_done); end
         end
         if (i == 43) begin
            n_checks++;
            if (remaining_shifts_done !== 1'b1) begin n_fail++; $display("FAIL gap_rem_done: got %b required 1", remaining_shifts_done); end
         end
      end
      n_checks++;
      if ({midstate, header_tail} !== {256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                                       96'hE0E1E2E3E4E5E6E7E8E9EAEB}) begin
         n_fail++; $display("FAIL gap_regs: got %h %h", midstate, header_tail);
      end
   endtask

   task automatic test_restart();
      step(1'b1, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
      step(1'b1, 1'b1, 8'h00, 1'b0);
      n_checks++;
      if ({start_found, midstate_shifts_done, remaining_shifts_done} !== 3'b100) begin
         n_fail++; $display("FAIL restart_flags: got %b required 100",
                            {start_found, midstate_shifts_done, remaining_shifts_done});
      end
      for (int i = 0; i < 44; i++) begin
         step(1'b1, 1'b0, 8'hAA, 1'b0);
         if (i == 30 || i == 31) begin
            n_checks++;
            if (midstate_shifts_done !== (i == 31)) begin
               n_fail++; $display("FAIL restart_mid_count%0d: got %b required %b", i, midstate_shifts_done, i == 31);
            end
         end
      end
      n_checks++;
      if ({midstate, header_tail, remaining_shifts_done} !== {{44{8'hAA}}, 1'b1}) begin
         n_fail++; $display("FAIL restart_regs: got %h %h %b", midstate, header_tail, remaining_shifts_done);
      end
   endtask

   task automatic test_sof_in_tail();
      step(1'b1, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 37; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
      n_checks++;
      if (midstate_shifts_done !== 1'b1) begin n_fail++; $display("FAIL tail_pre_mid: got %b required 1", midstate_shifts_done); end
      step(1'b1, 1'b1, 8'h00, 1'b0);
      n_checks++;
      if ({start_found, midstate_shifts_done} !== 2'b10) begin
         n_fail++; $display("FAIL tail_sof_flags: got %b required 10", {start_found, midstate_shifts_done});
      end
      // Next byte must go into midstate, proving the loader is back in the midstate phase
      step(1'b1, 1'b0, 8'h3C, 1'b0);
      n_checks++;
      if ({midstate[7:0], header_tail} !== {8'h3C, exp_tail()}) begin
         n_fail++; $display("FAIL tail_sof_route: got %h %h required 3c %h", midstate[7:0], header_tail, exp_tail());
      end
   endtask

   task automatic test_overflow_err();
      step(1'b1, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 44; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h99, 1'b0);
      n_checks++;
      if ({frame_err, midstate, header_tail} !== {1'b1, exp_mid(), exp_tail()}) begin
         n_fail++; $display("FAIL ovf_err: got %b %h %h required 1 %h %h", frame_err, midstate, header_tail, exp_mid(), exp_tail());
      end
      step(1'b1, 1'b1, 8'h00, 1'b0);
      n_checks++;
      if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ovf_sof_clear: got %b required 0", frame_err); end
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b0, 8'h42, 1'b0);
      n_checks++;
      if ({frame_err, midstate} !== {1'b1, 256'h0}) begin
         n_fail++; $display("FAIL pre_sof_err: got %b %h required 1 0", frame_err, midstate);
      end
   endtask

   task automatic test_reset_midframe();
      step(1'b1, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      n_checks++;
      if ({start_found, midstate_shifts_done, remaining_shifts_done, frame_err, midstate, header_tail} !== 356'h0) begin
         n_fail++; $display("FAIL midrst_outputs: got %b %h %h", frame_err, midstate, header_tail);
      end
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h55, 1'b0);
      n_checks++;
      if ({frame_err, midstate} !== {1'b1, 256'h0}) begin
         n_fail++; $display("FAIL midrst_ignore: got %b %h required 1 0", frame_err, midstate);
      end
      step(1'b1, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 44; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
      n_checks++;
      if ({midstate, header_tail, midstate_shifts_done, remaining_shifts_done, frame_err} !==
          {exp_mid(), exp_tail(), 3'b110} || midstate[255:248] !== 8'hC0 || header_tail[7:0] !== 8'hEB) begin
         n_fail++; $display("FAIL midrst_reload: got %h %h", midstate, header_tail);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 4000; c++) begin
         int roll;
         logic v, s, r;
         roll = int'($urandom_range(0, 999));
         r = (roll < 3);
         s = (roll >= 3 && roll < 30);
         v = s || (roll >= 300);
         step(v, s, 8'($urandom_range(0, 255)), r);
         n_checks++;
         if ({start_found, midstate_shifts_done, remaining_shifts_done, frame_err} !==
             {m_start, exp_mid_done(), exp_rem_done(), m_err}) begin
            n_fail++;
            $display("FAIL rand_flags cycle %0d: got %b required %b", c,
                     {start_found, midstate_shifts_done, remaining_shifts_done, frame_err},
                     {m_start, exp_mid_done(), exp_rem_done(), m_err});
         end
         n_checks++;
         if ({midstate, header_tail} !== {exp_mid(), exp_tail()}) begin
            n_fail++;
            $display("FAIL rand_regs cycle %0d: got %h %h required %h %h", c,
                     midstate, header_tail, exp_mid(), exp_tail());
         end
      end
   endtask

   initial begin
      rst = 1'b1; byte_valid = 1'b0; byte_sof = 1'b0; byte_data = 8'h00;
      model_reset();
      test_reset();
      test_basic_frame();
      test_gapped();
      test_restart();
      test_sof_in_tail();
      test_overflow_err();
      test_reset_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
